// File: rtl/ysyx_23060077_rd_arbiter.sv
// Two-master (IFU/LSU) read arbiter in front of the AXI bridge CPU read channel.
// Alternates on ties, holds the grant until the bridge's last beat, routes beats back.
module ysyx_23060077_rd_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 8
) (
   input  logic              aclk,
   input  logic              areset_n,

   input  logic              ifu_r_valid_i,
   input  logic [ADDR_W-1:0] ifu_r_addr_i,
   input  logic [2:0]        ifu_r_size_i,
   input  logic [LEN_W-1:0]  ifu_r_len_i,
   output logic              ifu_r_ready_o,
   output logic [DATA_W-1:0] ifu_r_data_o,
   output logic              ifu_r_last_o,

   input  logic              lsu_r_valid_i,
   input  logic [ADDR_W-1:0] lsu_r_addr_i,
   input  logic [2:0]        lsu_r_size_i,
   input  logic [LEN_W-1:0]  lsu_r_len_i,
   output logic              lsu_r_ready_o,
   output logic [DATA_W-1:0] lsu_r_data_o,
   output logic              lsu_r_last_o,

   output logic              bus_r_valid_o,
   output logic [ADDR_W-1:0] bus_r_addr_o,
   output logic [2:0]        bus_r_size_o,
   output logic [LEN_W-1:0]  bus_r_len_o,
   input  logic              bus_r_ready_i,
   input  logic [DATA_W-1:0] bus_r_data_i,
   input  logic              bus_r_last_i
);

   typedef enum logic [1:0] {IDLE, GNT_IFU, GNT_LSU} state_t;

   state_t            state, state_nxt;
   logic              last_grant_lsu;
   logic [LEN_W-1:0]  beat_cnt;
   logic [ADDR_W-1:0] addr_q;
   logic [2:0]        size_q;
   logic [LEN_W-1:0]  len_q;
   logic              pick_ifu, pick_lsu, done;

   // On a tie the master that did not win last time goes first.
   always_comb begin
      pick_lsu = lsu_r_valid_i && (!ifu_r_valid_i || !last_grant_lsu);
      pick_ifu = ifu_r_valid_i && !pick_lsu;
      done     = bus_r_ready_i && bus_r_last_i;
   end

   always_ff @(posedge aclk) begin
      if (!areset_n) state <= IDLE;
      else           state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (pick_lsu)      state_nxt = GNT_LSU;
            else if (pick_ifu) state_nxt = GNT_IFU;
         end
         GNT_IFU, GNT_LSU: if (done) state_nxt = IDLE;
         default:          state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (!areset_n) begin
         last_grant_lsu <= 1'b0;
         beat_cnt       <= '0;
         addr_q         <= '0;
         size_q         <= '0;
         len_q          <= '0;
      end else if (state == IDLE) begin
         if (pick_ifu || pick_lsu) begin
            last_grant_lsu <= pick_lsu;
            beat_cnt       <= '0;
            addr_q         <= pick_lsu ? lsu_r_addr_i : ifu_r_addr_i;
            size_q         <= pick_lsu ? lsu_r_size_i : ifu_r_size_i;
            len_q          <= pick_lsu ? lsu_r_len_i  : ifu_r_len_i;
         end
      end else if (bus_r_ready_i) begin
         beat_cnt <= beat_cnt + 1'b1;
      end
   end

   // Outputs are gated by areset_n so they read 0 for the whole reset window.
   always_comb begin
      bus_r_valid_o = 1'b0;
      bus_r_addr_o  = '0;
      bus_r_size_o  = '0;
      bus_r_len_o   = '0;
      ifu_r_ready_o = 1'b0;
      ifu_r_data_o  = '0;
      ifu_r_last_o  = 1'b0;
      lsu_r_ready_o = 1'b0;
      lsu_r_data_o  = '0;
      lsu_r_last_o  = 1'b0;
      if (areset_n && state != IDLE) begin
         bus_r_valid_o = 1'b1;
         bus_r_addr_o  = addr_q;
         bus_r_size_o  = size_q;
         bus_r_len_o   = len_q;
         if (state == GNT_IFU) begin
            ifu_r_ready_o = bus_r_ready_i;
            ifu_r_data_o  = bus_r_ready_i ? bus_r_data_i : '0;
            ifu_r_last_o  = done;
         end else begin
            lsu_r_ready_o = bus_r_ready_i;
            lsu_r_data_o  = bus_r_ready_i ? bus_r_data_i : '0;
            lsu_r_last_o  = done;
         end
      end
   end

   // A well-behaved bridge never delivers more beats than the latched length.
   a_beats_within_len: assert property (@(posedge aclk) disable iff (!areset_n)
      (state != IDLE) |-> (beat_cnt <= len_q));

endmodule

// File: tb/tb_ysyx_23060077_rd_arbiter.sv
// Directed bench for the IFU/LSU read arbiter, checked each cycle against a
// transaction-level model plus hand-computed expectations.
module tb_ysyx_23060077_rd_arbiter;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int LEN_W  = 8;

   logic              aclk = 1'b0;
   logic              areset_n;
   logic              ifu_r_valid_i, lsu_r_valid_i;
   logic [ADDR_W-1:0] ifu_r_addr_i, lsu_r_addr_i;
   logic [2:0]        ifu_r_size_i, lsu_r_size_i;
   logic [LEN_W-1:0]  ifu_r_len_i, lsu_r_len_i;
   logic              ifu_r_ready_o, ifu_r_last_o, lsu_r_ready_o, lsu_r_last_o;
   logic [DATA_W-1:0] ifu_r_data_o, lsu_r_data_o;
   logic              bus_r_valid_o;
   logic [ADDR_W-1:0] bus_r_addr_o;
   logic [2:0]        bus_r_size_o;
   logic [LEN_W-1:0]  bus_r_len_o;
   logic              bus_r_ready_i, bus_r_last_i;
   logic [DATA_W-1:0] bus_r_data_i;

   int checks = 0;
   int errors = 0;

   always #5 aclk = ~aclk;

   ysyx_23060077_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
      .aclk(aclk), .areset_n(areset_n),
      .ifu_r_valid_i(ifu_r_valid_i), .ifu_r_addr_i(ifu_r_addr_i), .ifu_r_size_i(ifu_r_size_i),
      .ifu_r_len_i(ifu_r_len_i), .ifu_r_ready_o(ifu_r_ready_o), .ifu_r_data_o(ifu_r_data_o),
      .ifu_r_last_o(ifu_r_last_o),
      .lsu_r_valid_i(lsu_r_valid_i), .lsu_r_addr_i(lsu_r_addr_i), .lsu_r_size_i(lsu_r_size_i),
      .lsu_r_len_i(lsu_r_len_i), .lsu_r_ready_o(lsu_r_ready_o), .lsu_r_data_o(lsu_r_data_o),
      .lsu_r_last_o(lsu_r_last_o),
      .bus_r_valid_o(bus_r_valid_o), .bus_r_addr_o(bus_r_addr_o), .bus_r_size_o(bus_r_size_o),
      .bus_r_len_o(bus_r_len_o), .bus_r_ready_i(bus_r_ready_i), .bus_r_data_i(bus_r_data_i),
      .bus_r_last_i(bus_r_last_i)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Model: who currently owns the bus, what it asked for, and the history of grants.
   typedef enum int {M_NONE, M_IFU, M_LSU} owner_t;
   owner_t            m_owner = M_NONE;
   owner_t            m_hist[$];
   logic [ADDR_W-1:0] m_addr;
   logic [2:0]        m_size;
   logic [LEN_W-1:0]  m_len;
   bit                m_live = 1'b0;

   always @(posedge aclk) begin
      owner_t w;
      m_live = 1'b1;
      if (!areset_n) begin
         m_owner = M_NONE;
         m_hist.delete();
      end else if (m_owner == M_NONE) begin
         w = M_NONE;
         if (ifu_r_valid_i && lsu_r_valid_i)
            w = (m_hist.size() == 0 || m_hist[$] == M_IFU) ? M_LSU : M_IFU;
         else if (lsu_r_valid_i) w = M_LSU;
         else if (ifu_r_valid_i) w = M_IFU;
         if (w != M_NONE) begin
            m_owner = w;
            m_hist.push_back(w);
            m_addr = (w == M_LSU) ? lsu_r_addr_i : ifu_r_addr_i;
            m_size = (w == M_LSU) ? lsu_r_size_i : ifu_r_size_i;
            m_len  = (w == M_LSU) ? lsu_r_len_i  : ifu_r_len_i;
         end
      end else if (bus_r_ready_i && bus_r_last_i) begin
         m_owner = M_NONE;
      end
   end

   always @(negedge aclk) begin
      owner_t o;
      bit     beat;
      if (m_live) begin
         o    = areset_n ? m_owner : M_NONE;
         beat = bus_r_ready_i === 1'b1;
         check("bus_valid", {63'd0, bus_r_valid_o}, {63'd0, o != M_NONE});
         check("bus_addr", {32'd0, bus_r_addr_o}, (o != M_NONE) ? {32'd0, m_addr} : 64'd0);
         check("bus_size", {61'd0, bus_r_size_o}, (o != M_NONE) ? {61'd0, m_size} : 64'd0);
         check("bus_len", {56'd0, bus_r_len_o}, (o != M_NONE) ? {56'd0, m_len} : 64'd0);
         check("ifu_ready", {63'd0, ifu_r_ready_o}, {63'd0, o == M_IFU && beat});
         check("ifu_data", {32'd0, ifu_r_data_o}, (o == M_IFU && beat) ? {32'd0, bus_r_data_i} : 64'd0);
         check("ifu_last", {63'd0, ifu_r_last_o}, {63'd0, o == M_IFU && beat && bus_r_last_i});
         check("lsu_ready", {63'd0, lsu_r_ready_o}, {63'd0, o == M_LSU && beat});
         check("lsu_data", {32'd0, lsu_r_data_o}, (o == M_LSU && beat) ? {32'd0, bus_r_data_i} : 64'd0);
         check("lsu_last", {63'd0, lsu_r_last_o}, {63'd0, o == M_LSU && beat && bus_r_last_i});
      end
   end

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   task automatic wait_grant(output logic [ADDR_W-1:0] addr);
      int n = 0;
      @(negedge aclk);
      while (!bus_r_valid_o && n < 20) begin
         @(negedge aclk);
         n++;
      end
      check("grant_timeout", {63'd0, bus_r_valid_o}, 64'd1);
      addr = bus_r_addr_o;
   endtask

   initial begin
      logic [ADDR_W-1:0] a;
      logic [3:0]        seq;
      int                ifu_beats, ifu_lasts, lsu_beats;
      logic [1:0]        pat [5];

      areset_n = 1'b0;
      bus_r_ready_i = 1'b0; bus_r_last_i = 1'b0; bus_r_data_i = '0;
      ifu_r_valid_i = 1'b1; ifu_r_addr_i = 32'h3000_0000; ifu_r_size_i = 3'd2; ifu_r_len_i = 8'd3;
      lsu_r_valid_i = 1'b1; lsu_r_addr_i = 32'h8000_0010; lsu_r_size_i = 3'd2; lsu_r_len_i = 8'd0;
      repeat (3) step();
      @(negedge aclk);
      check("rst_bus_valid", {63'd0, bus_r_valid_o}, 64'd0);

      // Release: first tie goes to LSU, visible one cycle after the deciding edge.
      step(); areset_n = 1'b1;
      @(negedge aclk);
      check("pre_grant_valid", {63'd0, bus_r_valid_o}, 64'd0);
      @(negedge aclk);
      check("lsu_first_valid", {63'd0, bus_r_valid_o}, 64'd1);
      check("lsu_first_addr", {32'd0, bus_r_addr_o}, 64'h8000_0010);
      check("lsu_first_size", {61'd0, bus_r_size_o}, 64'd2);
      check("lsu_first_len", {56'd0, bus_r_len_o}, 64'd0);

      step(); bus_r_ready_i = 1'b1; bus_r_last_i = 1'b1; bus_r_data_i = 32'hAAAA_0001;
      @(negedge aclk);
      check("lsu_beat_data", {32'd0, lsu_r_data_o}, 64'hAAAA_0001);
      check("lsu_beat_last", {63'd0, lsu_r_last_o}, 64'd1);
      check("lsu_beat_ifu_quiet", {63'd0, ifu_r_ready_o}, 64'd0);
      step(); bus_r_ready_i = 1'b0; bus_r_last_i = 1'b0; lsu_r_valid_i = 1'b0;
      @(negedge aclk);
      check("gap_after_lsu", {63'd0, bus_r_valid_o}, 64'd0);
      @(negedge aclk);
      check("ifu_grant_addr", {32'd0, bus_r_addr_o}, 64'h3000_0000);
      check("ifu_grant_len", {56'd0, bus_r_len_o}, 64'd3);

      // IFU burst D0..D3 with a ready-less last in between and an address change mid-grant.
      pat[0] = 2'b10; pat[1] = 2'b10; pat[2] = 2'b01; pat[3] = 2'b10; pat[4] = 2'b11;
      ifu_beats = 0; ifu_lasts = 0; lsu_beats = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         bus_r_ready_i = pat[i][1];
         bus_r_last_i  = pat[i][0];
         bus_r_data_i  = 32'hD000_0000 + ifu_beats;
         if (i == 1) ifu_r_addr_i = 32'h3000_0040;
         @(negedge aclk);
         ifu_beats += int'(ifu_r_ready_o);
         ifu_lasts += int'(ifu_r_last_o);
         lsu_beats += int'(lsu_r_ready_o) + int'(lsu_r_last_o);
         if (i == 3) check("addr_held", {32'd0, bus_r_addr_o}, 64'h3000_0000);
         if (i == 4) check("ifu_d3_data", {32'd0, ifu_r_data_o}, 64'hD000_0003);
      end
      step(); bus_r_ready_i = 1'b0; bus_r_last_i = 1'b0; ifu_r_valid_i = 1'b0;
      ifu_r_addr_i = 32'h3000_0000;
      @(negedge aclk);
      check("gap_after_ifu", {63'd0, bus_r_valid_o}, 64'd0);
      check("ifu_beat_count", 64'(ifu_beats), 64'd4);
      check("ifu_last_count", 64'(ifu_lasts), 64'd1);
      check("lsu_quiet_count", 64'(lsu_beats), 64'd0);

      // Both masters requesting back to back: grants must alternate LSU, IFU, LSU, IFU.
      step(); ifu_r_len_i = 8'd0; ifu_r_valid_i = 1'b1; lsu_r_valid_i = 1'b1;
      seq = '0;
      for (int i = 0; i < 4; i++) begin
         wait_grant(a);
         seq = {seq[2:0], a == 32'h8000_0010};
         step(); bus_r_ready_i = 1'b1; bus_r_last_i = 1'b1; bus_r_data_i = 32'h5500_0000 + i;
         step(); bus_r_ready_i = 1'b0; bus_r_last_i = 1'b0;
      end
      ifu_r_valid_i = 1'b0; lsu_r_valid_i = 1'b0;
      check("alternation", {60'd0, seq}, 64'hA);

      // Bridge strobes while idle must not reach either master.
      step(); step();
      step(); bus_r_ready_i = 1'b1; bus_r_last_i = 1'b1; bus_r_data_i = 32'h0000_1234;
      @(negedge aclk);
      check("idle_ifu_ready", {63'd0, ifu_r_ready_o}, 64'd0);
      check("idle_lsu_ready", {63'd0, lsu_r_ready_o}, 64'd0);
      check("idle_bus_valid", {63'd0, bus_r_valid_o}, 64'd0);
      step(); bus_r_ready_i = 1'b0; bus_r_last_i = 1'b0;
      @(negedge aclk);
      check("idle_stays", {63'd0, bus_r_valid_o}, 64'd0);

      // Reset on beat 2 of a len-3 IFU burst, then a fresh LSU request.
      step(); ifu_r_len_i = 8'd3; ifu_r_valid_i = 1'b1;
      wait_grant(a);
      check("rst_burst_grant", {32'd0, a}, 64'h3000_0000);
      for (int i = 0; i < 3; i++) begin
         step(); bus_r_ready_i = 1'b1; bus_r_data_i = 32'hE000_0000 + i;
         if (i == 2) areset_n = 1'b0;
      end
      @(negedge aclk);
      check("rst_mid_ifu_ready", {63'd0, ifu_r_ready_o}, 64'd0);
      check("rst_mid_ifu_data", {32'd0, ifu_r_data_o}, 64'd0);
      check("rst_mid_bus_valid", {63'd0, bus_r_valid_o}, 64'd0);
      step(); areset_n = 1'b1; bus_r_ready_i = 1'b0; ifu_r_valid_i = 1'b0;
      lsu_r_valid_i = 1'b1; lsu_r_addr_i = 32'h8000_0020;
      @(negedge aclk);
      check("post_rst_idle", {63'd0, bus_r_valid_o}, 64'd0);
      @(negedge aclk);
      check("post_rst_lsu_valid", {63'd0, bus_r_valid_o}, 64'd1);
      check("post_rst_lsu_addr", {32'd0, bus_r_addr_o}, 64'h8000_0020);
      step(); bus_r_ready_i = 1'b1; bus_r_last_i = 1'b1; bus_r_data_i = 32'hBBBB_0002;
      @(negedge aclk);
      check("post_rst_lsu_data", {32'd0, lsu_r_data_o}, 64'hBBBB_0002);
      step(); bus_r_ready_i = 1'b0; bus_r_last_i = 1'b0; lsu_r_valid_i = 1'b0;
      repeat (3) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
      $fatal(1);
   end
endmodule

// File: doc/ysyx_23060077_rd_arbiter.md
Name: ysyx_23060077_rd_arbiter

Overview:
- Two-master read arbiter placed directly upstream of the AXI master bridge's CPU read channel.
- Masters are the IFU (icache refill, bursts) and the LSU (loads, single beats).
- Grants one master at a time, registers its request and holds the grant until the bridge signals the last beat.
- Routes beat handshakes and data back to the granted master only.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, read data width.
- LEN_W, 8, burst length field width (beats-1).

Ports:
- aclk  in  1  clock
- areset_n  in  1  reset, synchronous, active-low
- ifu_r_valid_i  in  1  IFU read request, held until its last beat
- ifu_r_addr_i  in  ADDR_W  IFU read address
- ifu_r_size_i  in  3  IFU beat size (AXI encoding)
- ifu_r_len_i  in  LEN_W  IFU beats-1
- ifu_r_ready_o  out  1  IFU beat valid strobe
- ifu_r_data_o  out  DATA_W  IFU beat data
- ifu_r_last_o  out  1  IFU final beat
- lsu_r_valid_i  in  1  LSU read request, held until its last beat
- lsu_r_addr_i  in  ADDR_W  LSU read address
- lsu_r_size_i  in  3  LSU beat size
- lsu_r_len_i  in  LEN_W  LSU beats-1
- lsu_r_ready_o  out  1  LSU beat valid strobe
- lsu_r_data_o  out  DATA_W  LSU beat data
- lsu_r_last_o  out  1  LSU final beat
- bus_r_valid_o  out  1  request to bridge
- bus_r_addr_o  out  ADDR_W  latched address
- bus_r_size_o  out  3  latched size
- bus_r_len_o  out  LEN_W  latched len
- bus_r_ready_i  in  1  bridge beat strobe
- bus_r_data_i  in  DATA_W  bridge beat data
- bus_r_last_i  in  1  bridge final beat

Behaviour:
- Reset: aclk edge with areset_n=0 forces state=IDLE, last_grant=IFU, beat_cnt=0, latches=0. All outputs are 0 while in reset and in IDLE. Reset mid-burst abandons the burst with no completion pulse to either master.
- FSM states: IDLE, GNT_IFU, GNT_LSU.
- IDLE, only one valid: grant that master.
- IDLE, both valid: grant the master not equal to last_grant (alternating). After reset, LSU wins the first tie.
- On grant: latch addr/size/len from the winner into the bus latches, set last_grant, clear beat_cnt, and enter GNT_x on the next edge.
- Latency: valid seen in IDLE at cycle N -> bus_r_valid_o=1 from cycle N+1 with latched fields. Latched fields are stable for the whole grant; master input changes during the grant are ignored.
- bus_r_valid_o=1 in GNT_IFU and GNT_LSU; 0 in IDLE.
- In GNT_x:
  - x_r_ready_o = bus_r_ready_i and x_r_last_o = bus_r_last_i & bus_r_ready_i.
  - x_r_data_o = bus_r_data_i when bus_r_ready_i, else 0.
  - The other master's outputs stay 0.
- beat_cnt increments on each bus_r_ready_i in a grant state.
- Completion: bus_r_ready_i & bus_r_last_i returns the FSM to IDLE on the next edge.
  - bus_r_valid_o is therefore 0 for at least one cycle between grants, so the bridge never re-samples a stale request.
  - A master that still asserts valid after its last beat is treated as a new request.
- bus_r_last_i without bus_r_ready_i is ignored.
- bus_r_ready_i while in IDLE is ignored; no output pulses.
- Valid dropped by a master mid-grant does not abort; the grant runs to bus last.
- Consecutive LSU requests with IFU pending: IFU is served next (no starvation), and vice versa.

Test Plan:
- Reset with both valid=1 -> all outputs 0. First edge after release: grant LSU; bus_r_valid_o=1 one cycle later with lsu addr 0x8000_0010, size 2, len 0.
- IFU burst addr 0x3000_0000 len 3: bridge returns 4 beats D0..D3, last on D3 -> ifu_r_ready_o pulses 4 times, ifu_r_last_o only with D3, lsu outputs 0 throughout, bus_r_valid_o=0 the cycle after.
- Both valid continuously for 4 transactions (len 0) -> grants alternate LSU, IFU, LSU, IFU.
- IFU changes ifu_r_addr_i to 0x3000_0040 mid-grant -> bus_r_addr_o stays 0x3000_0000.
- bus_r_ready_i=1 pulsed in IDLE -> no ready/last on either master; state stays IDLE.
- areset_n=0 on beat 2 of a len-3 IFU burst -> next edge all outputs 0, state IDLE. A new LSU request after release is granted normally.
